// File: rtl/alu_pkg.sv
// Shared op-code and FSM state encodings for the ALU and its control block.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_ADD     = 3'b010,
        OP_MUL     = 3'b011,
        OP_SUB     = 3'b110,
        OP_INVALID = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } alu_state_e;

    function automatic logic is_iterative_op(logic [ALU_CTRL_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit (LSB first) per cycle, WIDTH cycles.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] step_sum;
    logic             last_step;

    // done_o and product_o reflect the step taken on this edge, so the final sum is
    // visible in the same cycle as the last step and the caller sees no extra latency.
    assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign done_o    = last_step;
    assign product_o = step_sum;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes; MUL is iterative, other ops single-cycle.
// Optional signed-overflow output ovf_o is built only when ALU_OVF_EN is defined.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
    input  logic [WIDTH-1:0]      data1_i,
    input  logic [WIDTH-1:0]      data2_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WIDTH-1:0]      data_o,
`ifdef ALU_OVF_EN
    output logic                  ovf_o,
`endif
    output logic                  zero_o
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             zero_q,  zero_d;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign sum  = data1_i + data2_i;
    assign diff = data1_i - data2_i;

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic op_ovf;

    // Signed overflow: effective operands share a sign that the result does not.
    function automatic logic add_sub_ovf(logic signed [WIDTH-1:0] a, logic signed [WIDTH-1:0] b,
                                         logic signed [WIDTH-1:0] s, logic is_sub);
        logic b_sign;
        b_sign = is_sub ? ~b[WIDTH-1] : b[WIDTH-1];
        return (a[WIDTH-1] == b_sign) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    always_comb begin
        op_ovf = 1'b0;
        case (ALUCtrl_i)
            OP_ADD:  op_ovf = add_sub_ovf(data1_i, data2_i, sum, 1'b0);
            OP_SUB:  op_ovf = add_sub_ovf(data1_i, data2_i, diff, 1'b1);
            default: op_ovf = 1'b0;
        endcase
    end
`endif

    always_comb begin
        op_res = '0;
        case (ALUCtrl_i)
            OP_AND:  op_res = data1_i & data2_i;
            OP_OR:   op_res = data1_i | data2_i;
            OP_ADD:  op_res = sum;
            OP_SUB:  op_res = diff;
            default: op_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .mcand_i   (data1_i),
        .mplier_i  (data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // ready_o is low outside IDLE, so a DONE->IDLE release can never coincide with an accept.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        zero_d    = zero_q;
        mul_start = 1'b0;
`ifdef ALU_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (is_iterative_op(ALUCtrl_i)) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_BUSY;
                    end else begin
                        data_d  = op_res;
                        zero_d  = (op_res == '0);
`ifdef ALU_OVF_EN
                        ovf_d   = op_ovf;
`endif
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    data_d  = mul_product;
                    zero_d  = (mul_product == '0);
`ifdef ALU_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
`ifdef ALU_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign valid_o = (state_q == ST_DONE);
    assign data_o  = data_q;
    assign zero_o  = valid_o && zero_q;
`ifdef ALU_OVF_EN
    assign ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, handshake/reset sequences, random ops.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   ALUCtrl_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         zero_o;
`ifdef ALU_OVF_EN
    logic         ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
`ifdef ALU_OVF_EN
        .ovf_o     (ovf_o),
`endif
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_d;
        logic         exp_z;
        logic         exp_ov;
        int           exp_lat;
        int           exp_busy;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: what the result should be, straight from the operation definitions.
    function automatic logic [W-1:0] model_data(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return p[W-1:0];
            3'b110:  return a - b;
            default: return '0;
        endcase
    endfunction

    function automatic logic model_ovf(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        longint s;
        if (op == 3'b010) s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 3'b110) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input int hold,
                          output logic [W-1:0] d, output logic z, output logic ov,
                          output int lat, output int busy);
        ready_i   = 1'b0;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        valid_i   = 1'b1;
        tick();
        valid_i   = 1'b0;
        data1_i   = $urandom;
        data2_i   = $urandom;
        ALUCtrl_i = 3'($urandom);
        lat  = 1;
        busy = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) busy++;
            if (noise) valid_i = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        valid_i = 1'b0;
        d = data_o;
        z = zero_o;
`ifdef ALU_OVF_EN
        ov = ovf_o;
`else
        ov = 1'b0;
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_data", 64'(data_o), 64'(d));
            check("hold_valid", 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("release_valid", 64'(valid_o), 64'd0);
        check("release_ready", 64'(ready_o), 64'd1);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;
        logic         z, ov;
        int           lat, busy;
        bit           seen;

        vecs[0]  = '{3'b010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1, 0};
        vecs[1]  = '{3'b110, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1, 0};
        vecs[2]  = '{3'b000, 32'hF0F0,      32'h0FF0,      32'h00F0,      1'b0, 1'b0, 1, 0};
        vecs[3]  = '{3'b001, 32'hF0F0,      32'h0FF0,      32'hFFF0,      1'b0, 1'b0, 1, 0};
        vecs[4]  = '{3'b011, 32'h1_0000,    32'h1_0001,    32'h0001_0000, 1'b0, 1'b0, 33, 32};
        vecs[5]  = '{3'b111, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0, 1, 0};
        vecs[6]  = '{3'b100, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1, 0};
        vecs[7]  = '{3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 1, 0};
        vecs[8]  = '{3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1, 0};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1, 0};
        vecs[10] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 33, 32};
        vecs[11] = '{3'b011, 32'h0,         32'h12345,     32'h0,         1'b1, 1'b0, 33, 32};
        vecs[12] = '{3'b110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1, 0};
        vecs[13] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 1, 0};

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_zero", 64'(zero_o), 64'd0);
`ifdef ALU_OVF_EN
        check("rst_ovf", 64'(ovf_o), 64'd0);
`endif

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0, d, z, ov, lat, busy);
            check($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_d));
            check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].exp_z));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
`ifdef ALU_OVF_EN
            check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].exp_ov));
`endif
        end

        // Result held under back-pressure while new requests are ignored.
        ALUCtrl_i = 3'b010; data1_i = 32'd100; data2_i = 32'd23; valid_i = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            ALUCtrl_i = 3'b001; data1_i = $urandom; data2_i = $urandom;
            valid_i = 1'(c % 2);
            check("bp_valid", 64'(valid_o), 64'd1);
            check("bp_data", 64'(data_o), 64'd123);
            check("bp_ready", 64'(ready_o), 64'd0);
            tick();
        end
        // Consume and request together: not accepted until the cycle after release.
        ALUCtrl_i = 3'b010; data1_i = 32'd7; data2_i = 32'd8; valid_i = 1'b1; ready_i = 1'b1;
        check("bp_data_last", 64'(data_o), 64'd123);
        tick();
        ready_i = 1'b0;
        check("release_no_accept_valid", 64'(valid_o), 64'd0);
        check("release_no_accept_ready", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        check("next_accept_valid", 64'(valid_o), 64'd1);
        check("next_accept_data", 64'(data_o), 64'd15);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;

        // Reset in the middle of a multiply aborts it.
        ALUCtrl_i = 3'b011; data1_i = 32'd1000; data2_i = 32'd1000; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        check("mid_mul_busy", 64'(ready_o), 64'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_data", 64'(data_o), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid_o) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_op(3'b010, 32'd2, 32'd3, 1'b0, 0, d, z, ov, lat, busy);
        check("post_abort_data", 64'(d), 64'd5);
        check("post_abort_lat", 64'(lat), 64'd1);

        // Random operations against the reference model, with request noise and back-pressure.
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = (n % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rb  = (n % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(rop, ra, rb, 1'b1, $urandom_range(0, 3), d, z, ov, lat, busy);
            check($sformatf("rnd%0d_op%0d_data", n, rop), 64'(d), 64'(model_data(rop, ra, rb)));
            check($sformatf("rnd%0d_zero", n), 64'(z), 64'(model_data(rop, ra, rb) == '0));
            check($sformatf("rnd%0d_lat", n), 64'(lat), (rop == 3'b011) ? 64'd33 : 64'd1);
`ifdef ALU_OVF_EN
            check($sformatf("rnd%0d_ovf", n), 64'(ov), 64'(model_ovf(rop, ra, rb)));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
